// File: rtl/lut_table_loader.sv
// Streams a 2^IN_W x OUT_W table in over a valid/ready config port, then serves registered lookups.
// Optional LUT_LAST_CHECK_EN enables cfg_last framing checks and the sticky cfg_err flag.
module lut_table_loader #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_last,
    input  logic             cfg_reload,
    input  logic [IN_W-1:0]  M0,
    input  logic             in_valid,
    output logic [OUT_W-1:0] M1,
    output logic             out_valid,
    output logic             loaded,
    output logic             cfg_err
);

    localparam int AW    = (IN_W > 0) ? IN_W : 1;
    localparam int DEPTH = 1 << IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [OUT_W-1:0] m1_q, m1_d;
    logic             ovld_q, ovld_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             last_addr;
    logic             lookup;

    // Table contents are deliberately not reset; only a full load makes them valid.
    logic [OUT_W-1:0] mem [DEPTH];

    assign cfg_ready = (state_q != READY);
    assign xfer      = cfg_valid && cfg_ready && !cfg_reload;
    assign last_addr = (waddr_q == AW'(DEPTH - 1));
    assign lookup    = (state_q == READY) && in_valid && !cfg_reload;

    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[waddr_q] <= cfg_data;
        end
    end

`ifndef LUT_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = cfg_last;
`endif

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        err_d   = err_q;
        ovld_d  = lookup;
        m1_d    = lookup ? mem[M0] : m1_q;

        if (cfg_reload) begin
            state_d = EMPTY;
            waddr_d = '0;
            err_d   = 1'b0;
        end else if (xfer) begin
            if (last_addr) begin
                state_d = READY;
            end else begin
                state_d = LOAD;
                waddr_d = waddr_q + AW'(1);
            end
`ifdef LUT_LAST_CHECK_EN
            // Early last aborts the load; a missing last only flags the error.
            if (cfg_last && !last_addr) begin
                err_d   = 1'b1;
                state_d = EMPTY;
                waddr_d = '0;
            end else if (!cfg_last && last_addr) begin
                err_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            waddr_q <= '0;
            m1_q    <= '0;
            ovld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            m1_q    <= m1_d;
            ovld_q  <= ovld_d;
            err_q   <= err_d;
        end
    end

    assign M1        = m1_q;
    assign out_valid = ovld_q;
    assign loaded    = (state_q == READY);
`ifdef LUT_LAST_CHECK_EN
    assign cfg_err   = err_q;
`else
    assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: load, lookup, reload, reset and framing cases.
module tb_lut_table_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_data;
    logic       cfg_last;
    logic       cfg_reload;
    logic [7:0] M0;
    logic       in_valid;
    logic [1:0] M1;
    logic       out_valid;
    logic       loaded;
    logic       cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    lut_table_loader #(.IN_W(8), .OUT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_reload (cfg_reload),
        .M0         (M0),
        .in_valid   (in_valid),
        .M1         (M1),
        .out_valid  (out_valid),
        .loaded     (loaded),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pattern 0: addr mod 4, 1: constant 2'b10, 2: 3 - (addr mod 4)
    function automatic logic [1:0] pat(input int p, input int a);
        case (p)
            0:       return 2'(a % 4);
            1:       return 2'b10;
            default: return 2'(3 - (a % 4));
        endcase
    endfunction

    task automatic xfer(input logic [1:0] d, input logic last);
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        cyc();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // Loads addresses lo..255 with pattern p; checks loaded stays low until the end.
    task automatic load_rest(input int p, input int lo, input string tag);
        for (int a = lo; a < 256; a++) begin
            if (a == 255) chk({tag, "_pre_loaded"}, loaded, 0);
            xfer(pat(p, a), a == 255);
        end
        chk({tag, "_loaded"}, loaded, 1);
        chk({tag, "_ready"}, cfg_ready, 0);
    endtask

    task automatic look(input logic [7:0] a, input logic [1:0] exp,
                        input string tag);
        M0       = a;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_m1"}, M1, exp);
    endtask

    task automatic reload();
        cfg_reload = 1'b1;
        cyc();
        cfg_reload = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        cfg_last   = 1'b0;
        cfg_reload = 1'b0;
        M0         = '0;
        in_valid   = 1'b0;
        #3;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_loaded", loaded, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_m1", M1, 0);
        chk("rst_err", cfg_err, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        load_rest(0, 0, "ld0");
        look(8'h4F, 2'b11, "lk4f");
        cyc();
        chk("idle_ov", out_valid, 0);
        chk("idle_m1_hold", M1, 2'b11);

        M0 = 8'h00; in_valid = 1'b1; cyc();
        chk("b2b0_ov", out_valid, 1);
        chk("b2b0", M1, 2'b00);
        M0 = 8'h01; cyc();
        chk("b2b1", M1, 2'b01);
        M0 = 8'h02; cyc();
        chk("b2b2", M1, 2'b10);
        in_valid = 1'b0;

        reload();
        chk("rl_loaded", loaded, 0);
        chk("rl_ready", cfg_ready, 1);
        M0 = 8'h10;
        in_valid = 1'b1;
        for (int a = 0; a < 100; a++) begin
            xfer(2'b01, 1'b0);
            if (a < 3) chk("load_ov", out_valid, 0);
        end
        in_valid = 1'b0;
        chk("load_m1_hold", M1, 2'b10);

        #2 rst_n = 1'b0;
        #1;
        chk("mrst_loaded", loaded, 0);
        chk("mrst_ready", cfg_ready, 1);
        chk("mrst_m1", M1, 0);
        cyc();
        rst_n = 1'b1;
        load_rest(1, 0, "ld1");
        look(8'hFF, 2'b10, "lkff");
        look(8'h4F, 2'b10, "lk4f_new");

        M0         = 8'h00;
        in_valid   = 1'b1;
        cfg_reload = 1'b1;
        cyc();
        cfg_reload = 1'b0;
        in_valid   = 1'b0;
        chk("rlr_ov", out_valid, 0);
        chk("rlr_loaded", loaded, 0);
        chk("rlr_ready", cfg_ready, 1);

        // Transfer during reload is dropped: the load still needs 256 entries.
        cfg_valid  = 1'b1;
        cfg_data   = 2'b01;
        cfg_reload = 1'b1;
        cyc();
        cfg_valid  = 1'b0;
        cfg_reload = 1'b0;
        load_rest(2, 0, "ld2");
        look(8'h00, 2'b11, "lk00_p2");
        look(8'h05, 2'b10, "lk05_p2");

        reload();
        for (int a = 0; a < 10; a++) xfer(pat(0, a), a == 9);
`ifdef LUT_LAST_CHECK_EN
        chk("early_err", cfg_err, 1);
        chk("early_loaded", loaded, 0);
        chk("early_ready", cfg_ready, 1);
        load_rest(2, 0, "ld3");
        look(8'h00, 2'b11, "lk00_p3");
        look(8'h0A, 2'b01, "lk0a_p3");
        chk("err_sticky", cfg_err, 1);
        reload();
        chk("err_clr", cfg_err, 0);
`else
        chk("noerr", cfg_err, 0);
        chk("nochk_loaded", loaded, 0);
        load_rest(0, 10, "ld3");
        look(8'h09, 2'b01, "lk09");
        look(8'hFE, 2'b10, "lkfe");
        chk("noerr_end", cfg_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
